// File: rtl/fp_arbiter_pkg.sv
// Shared constants and width helpers for the floating-point adder arbiter.
package fp_arbiter_pkg;

    localparam int unsigned STATS_CNT_W = 32;

    function automatic int unsigned fp_width(input int unsigned exp_w, input int unsigned frac_w);
        return 1 + exp_w + frac_w;
    endfunction

    function automatic int unsigned tag_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/fp_tag_fifo.sv
// Synchronous FIFO holding requester tags of operations issued to the adder.
module fp_tag_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/floating_point_adder_arbiter.sv
// Round-robin arbiter sharing one pipelined FP adder; results are routed back via a tag FIFO.
// Optional per-requester grant and stall counters when FP_ADDER_ARB_STATS_EN is defined.
module floating_point_adder_arbiter
    import fp_arbiter_pkg::*;
#(
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned FRAC_WIDTH = 23,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned TAG_DEPTH  = 8,
    localparam int unsigned FP_WIDTH  = fp_width(EXP_WIDTH, FRAC_WIDTH),
    localparam int unsigned CNT_W     = $clog2(TAG_DEPTH + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [NUM_REQ*FP_WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*FP_WIDTH-1:0] req_b_i,
    output logic [NUM_REQ-1:0]          rsp_valid_o,
    output logic [FP_WIDTH-1:0]         rsp_fp_o,
    output logic [FP_WIDTH-1:0]         add_a_o,
    output logic [FP_WIDTH-1:0]         add_b_o,
    output logic                        add_valid_o,
    input  logic [FP_WIDTH-1:0]         add_fp_i,
    input  logic                        add_valid_i,
    output logic [CNT_W-1:0]            in_flight_o,
    output logic                        error_o
`ifdef FP_ADDER_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STATS_CNT_W-1:0] grant_cnt_o,
    output logic [STATS_CNT_W-1:0]         stall_cnt_o
`endif
);
    localparam int unsigned TAG_W = tag_width(NUM_REQ);

    logic [FP_WIDTH-1:0] req_a_arr [NUM_REQ];
    logic [FP_WIDTH-1:0] req_b_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_a_arr[gi] = req_a_i[gi*FP_WIDTH +: FP_WIDTH];
        assign req_b_arr[gi] = req_b_i[gi*FP_WIDTH +: FP_WIDTH];
    end

    logic [TAG_W-1:0]    ptr_q, ptr_d, grant_idx, cand, tag_out;
    logic                grant_found, accept, pop, fifo_full, fifo_empty;
    logic [FP_WIDTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d, rsp_fp_q, rsp_fp_d;
    logic                add_valid_q, add_valid_d, error_q, error_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;

    // First valid requester at or after ptr, with wrap-around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = TAG_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        accept      = grant_found && !fifo_full && !rst_i;
        req_ready_o = accept ? (NUM_REQ'(1) << grant_idx) : '0;
        pop         = add_valid_i && !fifo_empty;
    end

    always_comb begin
        ptr_d       = ptr_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_valid_d = accept;
        if (accept) begin
            ptr_d   = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
            add_a_d = req_a_arr[grant_idx];
            add_b_d = req_b_arr[grant_idx];
        end
        rsp_valid_d = pop ? (NUM_REQ'(1) << tag_out) : '0;
        rsp_fp_d    = pop ? add_fp_i : rsp_fp_q;
        error_d     = error_q || (add_valid_i && fifo_empty);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_valid_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_fp_q    <= '0;
            error_q     <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_valid_q <= add_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fp_q    <= rsp_fp_d;
            error_q     <= error_d;
        end
    end

    fp_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .data_i  (grant_idx),
        .pop_i   (pop),
        .data_o  (tag_out),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (in_flight_o)
    );

    assign add_a_o     = add_a_q;
    assign add_b_o     = add_b_q;
    assign add_valid_o = add_valid_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_fp_o    = rsp_fp_q;
    assign error_o     = error_q;

`ifdef FP_ADDER_ARB_STATS_EN
    logic [NUM_REQ-1:0][STATS_CNT_W-1:0] grant_cnt_q, grant_cnt_d;
    logic [STATS_CNT_W-1:0]              stall_cnt_q, stall_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (accept && (grant_cnt_q[grant_idx] != '1)) begin
            grant_cnt_d[grant_idx] = grant_cnt_q[grant_idx] + STATS_CNT_W'(1);
        end
        if ((|req_valid_i) && !accept && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STATS_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign grant_cnt_o = grant_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
